// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths, types and helpers for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

   localparam int WB_DW = 64;
   localparam int RF_AW = 5;

   typedef logic [WB_DW-1:0] wb_data_t;
   typedef logic [RF_AW-1:0] rf_addr_t;

   localparam rf_addr_t RF_ZERO = '0;

   typedef struct packed {
      logic     en;
      rf_addr_t rd;
      wb_data_t data;
      logic     mdiv;
   } wr_port_t;

   // A GPR write to r0 is architecturally a no-op; HI/LO writes use rd=0 legitimately.
   function automatic logic is_r0_write(input rf_addr_t rd, input logic mdiv);
      return (rd == RF_ZERO) && !mdiv;
   endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Pipeline, MDU and register-file write-port signals shared by the arbiter and its users.
interface wb_port_arbiter_if;
   import wb_port_arbiter_pkg::*;

   logic     pipe_wr;
   rf_addr_t pipe_rd;
   wb_data_t pipe_data;
   logic     pipe_mdiv;
   logic     md_valid;
   wb_data_t md_data;
   logic     md_ready;
   logic     pipe_stall;
   logic     hilo_pending;
   logic     wr_en;
   rf_addr_t wr_rd;
   wb_data_t wr_data;
   logic     wr_mdiv;
   logic     proto_err;

   modport slave (
      input  pipe_wr, pipe_rd, pipe_data, pipe_mdiv, md_valid, md_data,
      output md_ready, pipe_stall, hilo_pending, wr_en, wr_rd, wr_data, wr_mdiv, proto_err
   );

   modport master (
      output pipe_wr, pipe_rd, pipe_data, pipe_mdiv, md_valid, md_data,
      input  md_ready, pipe_stall, hilo_pending, wr_en, wr_rd, wr_data, wr_mdiv, proto_err
   );

endinterface

// File: rtl/wb_md_fifo.sv
// DEPTH x 64 FIFO buffering MDU results; head is read combinationally for the grant mux.
module wb_md_fifo
   import wb_port_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  wb_data_t                 push_data_i,
   output wb_data_t                 head_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wb_data_t          mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q;
   logic [PW-1:0]     rd_ptr_q;
   logic [CW-1:0]     count_q;

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   // Pointers are exactly log2(DEPTH) bits, so they wrap without explicit compare.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_q + CW'(push_i) - CW'(pop_i);
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between pipeline writeback (priority)
// and buffered MDU results, with a starvation counter that forces a pipeline stall.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic               clk,
   input  logic               rst,
   wb_port_arbiter_if.slave   bus
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int WW = $clog2(STARVE_MAX + 1);
   localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_MAX);

   logic          fifo_push;
   logic          fifo_pop;
   wb_data_t      fifo_head;
   logic [CW-1:0] fifo_count;
   logic          fifo_full;
   logic          fifo_empty;

   logic          stall;
   logic          fifo_grant;
   logic          pipe_grant;

   logic [WW-1:0] wait_q, wait_d;
   logic          proto_q, proto_d;
   wr_port_t      wr_q, wr_d;

   wb_md_fifo #(.DEPTH(DEPTH)) u_md_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (fifo_push),
      .pop_i       (fifo_pop),
      .push_data_i (bus.md_data),
      .head_o      (fifo_head),
      .count_o     (fifo_count),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   // Stall comes only from a register so it cannot form a loop through pipe_wr.
   assign stall      = (wait_q == WAIT_MAX);
   assign fifo_push  = bus.md_valid & ~fifo_full;
   assign fifo_grant = ~fifo_empty & (stall | ~bus.pipe_wr);
   assign pipe_grant = bus.pipe_wr & ~stall & ~fifo_grant;
   assign fifo_pop   = fifo_grant;

   always_comb begin
      wr_d    = wr_q;
      wr_d.en = 1'b0;
      if (fifo_grant) begin
         wr_d.en   = 1'b1;
         wr_d.rd   = RF_ZERO;
         wr_d.data = fifo_head;
         wr_d.mdiv = 1'b1;
      end else if (pipe_grant) begin
         wr_d.en   = ~is_r0_write(bus.pipe_rd, bus.pipe_mdiv);
         wr_d.rd   = bus.pipe_rd;
         wr_d.data = bus.pipe_data;
         wr_d.mdiv = bus.pipe_mdiv;
      end
   end

   always_comb begin
      wait_d = wait_q;
      if (fifo_grant || fifo_empty) begin
         wait_d = '0;
      end else if (!stall) begin
         wait_d = wait_q + WW'(1);
      end
   end

   // A request during a forced stall is dropped and remembered until reset.
   assign proto_d = proto_q | (stall & bus.pipe_wr);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_q  <= '0;
         proto_q <= 1'b0;
         wr_q    <= '0;
      end else begin
         wait_q  <= wait_d;
         proto_q <= proto_d;
         wr_q    <= wr_d;
      end
   end

   assign bus.md_ready     = ~fifo_full;
   assign bus.pipe_stall   = stall;
   assign bus.hilo_pending = (fifo_count != '0) | (wr_q.en & wr_q.mdiv);
   assign bus.wr_en        = wr_q.en;
   assign bus.wr_rd        = wr_q.rd;
   assign bus.wr_data      = wr_q.data;
   assign bus.wr_mdiv      = wr_q.mdiv;
   assign bus.proto_err    = proto_q;

endmodule
